// File: rtl/fifo_word_serializer_if.sv
// FIFO read port plus valid/ready beat stream between the serializer and its neighbours.
interface fifo_word_serializer_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
);
  logic                 fifo_empty;
  logic [IN_WIDTH-1:0]  fifo_rd_data;
  logic                 fifo_rd_en;
  logic                 out_valid;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_last;
  logic                 out_ready;

  modport master (
    input  fifo_empty, fifo_rd_data, out_ready,
    output fifo_rd_en, out_valid, out_data, out_last
  );

  modport slave (
    output fifo_empty, fifo_rd_data, out_ready,
    input  fifo_rd_en, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fifo_word_serializer.sv
// Pops FIFO words and emits them LSB-slice first as OUT_WIDTH beats, framing every
// FRAME_WORDS words with out_last. Reload happens on the last-beat handshake for zero bubbles.
module fifo_word_serializer #(
  parameter int IN_WIDTH    = 32,
  parameter int OUT_WIDTH   = 8,
  parameter int FRAME_WORDS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_enable,
  output logic o_busy,
  fifo_word_serializer_if.master bus
);
  localparam int BEATS  = IN_WIDTH / OUT_WIDTH;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int WORD_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  if ((IN_WIDTH % OUT_WIDTH) != 0 || BEATS < 2 || FRAME_WORDS < 1) begin : g_bad_params
    $error("fifo_word_serializer: illegal parameter combination");
  end

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t              r_state, w_state_nxt;
  logic [IN_WIDTH-1:0] r_shift, w_shift_nxt;
  logic [BEAT_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;
  logic [WORD_W-1:0]   r_word_cnt, w_word_cnt_nxt;

  logic w_valid, w_accept, w_last_beat, w_last_word, w_take, w_pop;

  assign w_valid     = (r_state == S_SHIFT);
  assign w_accept    = w_valid && bus.out_ready;
  assign w_last_beat = (r_beat_cnt == BEAT_W'(BEATS - 1));
  assign w_last_word = (r_word_cnt == WORD_W'(FRAME_WORDS - 1));
  assign w_take      = (r_state == S_IDLE) || (w_accept && w_last_beat);
  // rst gating keeps the pop request quiet while the block is held in reset.
  assign w_pop       = w_take && i_enable && !bus.fifo_empty && !rst;

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_beat_cnt_nxt = r_beat_cnt;
    w_word_cnt_nxt = r_word_cnt;
    if (w_accept) begin
      if (!w_last_beat) begin
        w_shift_nxt    = r_shift >> OUT_WIDTH;
        w_beat_cnt_nxt = r_beat_cnt + 1'b1;
      end else begin
        w_word_cnt_nxt = w_last_word ? '0 : r_word_cnt + 1'b1;
        w_state_nxt    = S_IDLE;
      end
    end
    // A pop overrides the drain-to-idle above, giving back-to-back words.
    if (w_pop) begin
      w_shift_nxt    = bus.fifo_rd_data;
      w_beat_cnt_nxt = '0;
      w_state_nxt    = S_SHIFT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_beat_cnt <= '0;
      r_word_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_word_cnt <= w_word_cnt_nxt;
    end
  end

  assign bus.fifo_rd_en = w_pop;
  assign bus.out_valid  = w_valid;
  assign bus.out_data   = r_shift[OUT_WIDTH-1:0];
  assign bus.out_last   = w_valid && w_last_beat && w_last_word;
  assign o_busy         = w_valid;
endmodule
